beverage_dispense_demux: RTL
============================

// Module: beverage_dispense_demux
// PURPOSE
//  Output-side counterpart of the 4:1 beverage select mux: one pour order in,
//  routed to one of four valves (beer, wine, rum, whiskey). Holds that valve
//  open for the ordered number of cycles and tracks each tank's level.
//  Sits between the order front-end (valid/ready) and the valve drivers.
// PARAMETERS
//  AMT_W        8     width of order amount (cycles of pour)
//  LEVEL_W      10    width of each tank level counter
//  LEVEL_INIT   1000  tank level loaded at reset and on refill
//  PRIME_CYCLES 2     valves-closed delay between accept and first pour cycle
// PORTS
//  clk            in   1      rising-edge clock, single domain
//  reset          in   1      synchronous, active-high reset
//  order_valid    in   1      order request
//  order_ready    out  1      1 only in IDLE; accept = order_valid & order_ready
//  order_sel      in   2      00 beer, 01 wine, 10 rum, 11 whiskey (same coding as mux)
//  order_amt      in   AMT_W  requested pour cycles
//  abort          in   1      stop the current pour
//  refill_valid   in   1      reload one tank to LEVEL_INIT
//  refill_sel     in   2      tank to refill, same coding as order_sel
//  valve_beer     out  1      registered; at most one valve high at any time
//  valve_wine     out  1
//  valve_rum      out  1
//  valve_whiskey  out  1
//  busy           out  1      1 in PRIME, POUR, DONE
//  done           out  1      1-cycle pulse in DONE
//  short_pour     out  1      valid with done: poured_cnt < ordered amount
//  poured_cnt     out  AMT_W  cycles poured; held from DONE until next accept
//  tank_empty     out  4      {beer,wine,rum,whiskey} level==0 flags, combinational
// BEHAVIOUR
//  Reset: state IDLE; all valves 0; busy, done, short_pour, poured_cnt = 0;
//   all four levels = LEVEL_INIT; prime counter = 0; latched sel/amt = 0.
//  States: IDLE -> PRIME -> POUR -> DONE -> IDLE.
//  IDLE: order_ready=1. On accept, latch sel/amt, clear poured_cnt, then:
//   amt==0 -> DONE (short_pour=0).
//   level[sel]==0 -> DONE (short_pour=1).
//   otherwise -> PRIME.
//  PRIME: valves closed for exactly PRIME_CYCLES cycles, then POUR.
//  POUR: valve[sel]=1. Each POUR cycle: level[sel]-=1, poured_cnt+=1.
//   Go to DONE on the edge where poured_cnt reaches amt, or level reaches 0.
//   Valve is low in the DONE cycle. First valve-high cycle = accept + PRIME_CYCLES + 1.
//  abort in PRIME or POUR: no decrement that cycle; next state DONE; valve low
//   from the next edge. Abort in IDLE or DONE is ignored.
//  DONE: done=1 for one cycle; short_pour = (poured_cnt != amt); then IDLE.
//  Refill: honoured only in IDLE, on the same edge as any accept; ignored otherwise.
//   Refill and order of the same tank on one edge: refill wins the level; the
//   empty check uses the pre-refill level.
//  Level never wraps below 0. poured_cnt never exceeds amt.
//  Reset mid-pour: valve closes on that edge; the order is dropped with no done.
// STRUCTURE
//  Shared package: localparam codes SEL_BEER=2'd0, SEL_WINE=2'd1, SEL_RUM=2'd2,
//   SEL_WHISKEY=2'd3; state encoding S_IDLE/S_PRIME/S_POUR/S_DONE (2 bits).
//  One sub-module, tank_level: LEVEL_W down-counter with load (refill),
//   decrement enable, and empty flag. Instantiated 4 times.
//  Top level holds the FSM, prime counter, pour counter and the one-hot valve decode.
// TESTING
//  1. Reset, order sel=01 amt=5 -> wine high exactly 5 cycles, starting at accept+3;
//     done=1, short_pour=0, poured_cnt=5, wine level=995.
//  2. LEVEL_INIT=3 build, order sel=11 amt=10 -> whiskey high 3 cycles;
//     short_pour=1, poured_cnt=3, tank_empty=0001.
//  3. abort asserted in the 2nd POUR cycle of sel=00 amt=8 -> beer high 2 cycles;
//     done next cycle, poured_cnt=1, short_pour=1.
//  4. amt=0 -> no valve activity; done 1 cycle after accept; short_pour=0.
//     Order to an empty tank -> done with short_pour=1, no valve.
//  5. refill_valid during POUR is ignored. Refill of rum in IDLE after drain ->
//     rum level=LEVEL_INIT, tank_empty[1]=0.
//  6. Exhaustive sel 00..11 x amt {1,2,255}: each cycle, valves one-hot or zero,
//     only valve[sel] ever high; reset mid-POUR closes the valve on that edge.

Source files
------------

// File: rtl/beverage_dispense_demux_pkg.sv
// Shared codes for the beverage dispense path: tank select coding and FSM states.
package beverage_dispense_demux_pkg;

  localparam logic [1:0] SEL_BEER    = 2'd0;
  localparam logic [1:0] SEL_WINE    = 2'd1;
  localparam logic [1:0] SEL_RUM     = 2'd2;
  localparam logic [1:0] SEL_WHISKEY = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_POUR  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bit index of the returned vector equals the select code.
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    sel_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/beverage_dispense_demux_tank_level.sv
// One tank's level: reloads on reset/refill, counts down one per pour cycle, saturates at 0.
module tank_level #(
  parameter int LEVEL_W    = 10,
  parameter int LEVEL_INIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  output logic [LEVEL_W-1:0] level,
  output logic               empty
);

  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (reset || load)
      level <= LEVEL_W'(LEVEL_INIT);
    else if (dec && !empty)
      level <= level - LEVEL_W'(1);
  end

endmodule

// File: rtl/beverage_dispense_demux.sv
// Routes one pour order to one of four valves, holds it open for the ordered cycles,
// and tracks the four tank levels.
module beverage_dispense_demux
  import beverage_dispense_demux_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter int LEVEL_W      = 10,
  parameter int LEVEL_INIT   = 1000,
  parameter int PRIME_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             order_valid,
  output logic             order_ready,
  input  logic [1:0]       order_sel,
  input  logic [AMT_W-1:0] order_amt,
  input  logic             abort,
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  output logic             valve_beer,
  output logic             valve_wine,
  output logic             valve_rum,
  output logic             valve_whiskey,
  output logic             busy,
  output logic             done,
  output logic             short_pour,
  output logic [AMT_W-1:0] poured_cnt,
  output logic [3:0]       tank_empty
);

  localparam int PRIME_W    = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
  localparam int PRIME_LAST = (PRIME_CYCLES > 0) ? PRIME_CYCLES - 1 : 0;

  state_t                      state;
  logic [1:0]                  sel_q;
  logic [AMT_W-1:0]            amt_q;
  logic [PRIME_W-1:0]          prime_cnt;
  logic [3:0]                  valve_q;
  logic [3:0]                  load, dec, empty;
  logic [3:0][LEVEL_W-1:0]     level;
  logic                        accept;
  logic [AMT_W-1:0]            poured_inc;
  logic                        last_unit;

  assign order_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign accept      = order_valid && order_ready;
  assign poured_inc  = poured_cnt + AMT_W'(1);
  assign last_unit   = (level[sel_q] == LEVEL_W'(1));

  assign valve_beer    = valve_q[SEL_BEER];
  assign valve_wine    = valve_q[SEL_WINE];
  assign valve_rum     = valve_q[SEL_RUM];
  assign valve_whiskey = valve_q[SEL_WHISKEY];
  assign tank_empty    = {empty[SEL_BEER], empty[SEL_WINE], empty[SEL_RUM], empty[SEL_WHISKEY]};

  // An aborted pour cycle does not draw from the tank.
  always_comb begin
    load = '0;
    dec  = '0;
    if (state == S_IDLE && refill_valid) load = sel_onehot(refill_sel);
    if (state == S_POUR && !abort)       dec  = sel_onehot(sel_q);
  end

  tank_level #(.LEVEL_W(LEVEL_W), .LEVEL_INIT(LEVEL_INIT)) u_tank [3:0] (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .dec   (dec),
    .level (level),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sel_q      <= '0;
      amt_q      <= '0;
      prime_cnt  <= '0;
      poured_cnt <= '0;
      valve_q    <= '0;
      short_pour <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          sel_q      <= order_sel;
          amt_q      <= order_amt;
          poured_cnt <= '0;
          prime_cnt  <= '0;
          // Empty check sees the level before any same-edge refill.
          if (order_amt == '0) begin
            state      <= S_DONE;
            short_pour <= 1'b0;
          end else if (empty[order_sel]) begin
            state      <= S_DONE;
            short_pour <= 1'b1;
          end else if (PRIME_CYCLES == 0) begin
            state   <= S_POUR;
            valve_q <= sel_onehot(order_sel);
          end else begin
            state <= S_PRIME;
          end
        end
        S_PRIME: begin
          if (abort) begin
            state      <= S_DONE;
            short_pour <= (poured_cnt != amt_q);
          end else if (prime_cnt == PRIME_W'(PRIME_LAST)) begin
            state     <= S_POUR;
            prime_cnt <= '0;
            valve_q   <= sel_onehot(sel_q);
          end else begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
          end
        end
        S_POUR: begin
          if (abort) begin
            state      <= S_DONE;
            valve_q    <= '0;
            short_pour <= (poured_cnt != amt_q);
          end else begin
            poured_cnt <= poured_inc;
            if (poured_inc == amt_q || last_unit) begin
              state      <= S_DONE;
              valve_q    <= '0;
              short_pour <= (poured_inc != amt_q);
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          short_pour <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
